// File: rtl/dmem_lsu.sv
// -----------------------------------------------------------------------------
// dmem_lsu -- byte-addressed data memory with a load/store request port.
//
// A single request is accepted at a time. Stores commit and loads sample
// memory at the acceptance edge. The response is a one-cycle strobe that
// arrives WAIT_CYCLES + 1 cycles after acceptance, with the response data
// and fault flag held until the next response.
//
// Parameters
//   DEPTH_BYTES  byte capacity (power of two, >= 16)
//   WAIT_CYCLES  extra access cycles, 0..7
//
// Ports
//   clk           clock, rising edge
//   resetn        asynchronous active-low reset
//   req_valid     request present
//   req_ready     block can accept a request (IDLE and out of reset)
//   req_we        1 = store, 0 = load
//   req_size      00 byte, 01 half, 10 word, 11 illegal (faults)
//   req_unsigned  zero-extend loads when 1, sign-extend when 0
//   req_addr      byte address
//   req_wdata     store data, lane 0 = bits 7:0
//   rsp_valid     one-cycle response strobe
//   rsp_rdata     extended load data; 0 for stores and faults
//   rsp_fault     access rejected; qualified by rsp_valid
//
// Handshake: a request transfers on a rising edge where req_valid and
// req_ready are both high; req_valid is ignored whenever req_ready is low.
// There is no backpressure on the response side.
//
// Build option
//   DMEM_MISALIGN_TRAP_EN  defined:   misaligned half/word accesses fault.
//                          undefined: the low address bits are cleared
//                                     for half/word accesses instead.
// -----------------------------------------------------------------------------
module dmem_lsu #(
    parameter int DEPTH_BYTES = 4096,
    parameter int WAIT_CYCLES = 1
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [1:0]  req_size,
    input  logic        req_unsigned,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    output logic [31:0] rsp_rdata,
    output logic        rsp_fault
);

    localparam int AW = $clog2(DEPTH_BYTES);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2
    } state_t;

    // FSM state is kept as a named register so checkers can bind to it.
    state_t      state;
    logic [2:0]  cnt;
    logic [31:0] pend_rdata;
    logic        pend_fault;

    logic [7:0]  mem [DEPTH_BYTES];

    logic        accept;
    logic [3:0]  be;
    logic [2:0]  nbytes;
    logic [AW-1:0] align_mask;
    logic [AW-1:0] base;
    logic        size_bad;
    logic        range_bad;
    logic        misalign;
    logic        fault;
    logic [32:0] last_byte;
    logic [7:0]  rbyte [4];
    logic [31:0] load_val;
    logic [31:0] rdata_next;

    assign req_ready = resetn && (state == IDLE);
    assign accept    = req_valid && req_ready;

    // ---------------------------------------------------------------------
    // Request decode: byte enables, fault detection, effective address.
    // ---------------------------------------------------------------------
    always_comb begin
        be         = 4'b0001;
        nbytes     = 3'd1;
        align_mask = '0;
        size_bad   = 1'b0;
        misalign   = 1'b0;
        case (req_size)
            2'b00: begin
                be     = 4'b0001;
                nbytes = 3'd1;
            end
            2'b01: begin
                be         = 4'b0011;
                nbytes     = 3'd2;
                align_mask = AW'(1);
`ifdef DMEM_MISALIGN_TRAP_EN
                misalign   = req_addr[0];
`endif
            end
            2'b10: begin
                be         = 4'b1111;
                nbytes     = 3'd4;
                align_mask = AW'(3);
`ifdef DMEM_MISALIGN_TRAP_EN
                misalign   = |req_addr[1:0];
`endif
            end
            default: begin
                be       = 4'b0000;
                nbytes   = 3'd1;
                size_bad = 1'b1;
            end
        endcase

        // Range check uses the raw address in 33 bits so a request near
        // 0xFFFFFFFF cannot wrap around into range.
        last_byte = {1'b0, req_addr} + {30'b0, nbytes} - 33'd1;
        range_bad = (last_byte >= 33'(DEPTH_BYTES));
        fault     = size_bad | range_bad | misalign;

`ifdef DMEM_MISALIGN_TRAP_EN
        // Misaligned accesses fault, so no address forcing is needed.
        base = req_addr[AW-1:0];
`else
        // Silently align half/word accesses to their natural boundary.
        base = req_addr[AW-1:0] & ~align_mask;
`endif
    end

    // ---------------------------------------------------------------------
    // Load path: gather up to four little-endian bytes and extend.
    // ---------------------------------------------------------------------
    always_comb begin
        for (int k = 0; k < 4; k++) begin
            rbyte[k] = mem[base + AW'(k)];
        end
        load_val = '0;
        case (req_size)
            2'b00: load_val = req_unsigned ? {24'b0, rbyte[0]}
                                           : {{24{rbyte[0][7]}}, rbyte[0]};
            2'b01: load_val = req_unsigned ? {16'b0, rbyte[1], rbyte[0]}
                                           : {{16{rbyte[1][7]}}, rbyte[1], rbyte[0]};
            2'b10: load_val = {rbyte[3], rbyte[2], rbyte[1], rbyte[0]};
            default: load_val = '0;
        endcase
        rdata_next = (fault || req_we) ? 32'b0 : load_val;
    end

    // ---------------------------------------------------------------------
    // Storage: not reset, so contents survive resetn. Faulting stores and
    // requests made while resetn is low never reach here (req_ready gates it).
    // ---------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (accept && req_we && !fault) begin
            for (int k = 0; k < 4; k++) begin
                if (be[k]) begin
                    mem[base + AW'(k)] <= req_wdata[8*k +: 8];
                end
            end
        end
    end

    // ---------------------------------------------------------------------
    // Control FSM. Response registers only change when entering RESP, so
    // rsp_rdata / rsp_fault hold from one response to the next.
    // ---------------------------------------------------------------------
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state      <= IDLE;
            cnt        <= 3'd0;
            pend_rdata <= 32'b0;
            pend_fault <= 1'b0;
            rsp_valid  <= 1'b0;
            rsp_rdata  <= 32'b0;
            rsp_fault  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    rsp_valid <= 1'b0;
                    if (accept) begin
                        if (WAIT_CYCLES == 0) begin
                            state     <= RESP;
                            rsp_valid <= 1'b1;
                            rsp_rdata <= rdata_next;
                            rsp_fault <= fault;
                        end else begin
                            state      <= BUSY;
                            cnt        <= 3'(WAIT_CYCLES);
                            pend_rdata <= rdata_next;
                            pend_fault <= fault;
                        end
                    end
                end
                BUSY: begin
                    // The cycle in which the counter reads 1 is the last wait cycle.
                    if (cnt == 3'd1) begin
                        state     <= RESP;
                        cnt       <= 3'd0;
                        rsp_valid <= 1'b1;
                        rsp_rdata <= pend_rdata;
                        rsp_fault <= pend_fault;
                    end else begin
                        cnt <= cnt - 3'd1;
                    end
                end
                RESP: begin
                    rsp_valid <= 1'b0;
                    state     <= IDLE;
                end
                default: begin
                    state     <= IDLE;
                    rsp_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dmem_lsu.sv
// -----------------------------------------------------------------------------
// tb_dmem_lsu -- directed self-checking bench for dmem_lsu.
//
// Three instances share one clock:
//   d=0  WAIT_CYCLES=1  functional, boundary and alignment vectors
//   d=1  WAIT_CYCLES=3  reset during an in-flight store
//   d=2  WAIT_CYCLES=0  req_valid held high back-to-back
//
// Outputs are sampled on the falling edge. Latency is the number of falling
// edges after the acceptance edge up to the first one where rsp_valid is
// seen high; this equals the number of clocks from acceptance until the
// rising edge that captures rsp_valid, i.e. WAIT_CYCLES + 1.
// -----------------------------------------------------------------------------
module tb_dmem_lsu;

    logic        clk;
    logic        resetn       [3];
    logic        req_valid    [3];
    logic        req_ready    [3];
    logic        req_we       [3];
    logic [1:0]  req_size     [3];
    logic        req_unsigned [3];
    logic [31:0] req_addr     [3];
    logic [31:0] req_wdata    [3];
    logic        rsp_valid    [3];
    logic [31:0] rsp_rdata    [3];
    logic        rsp_fault    [3];

    int checks = 0;
    int errors = 0;
    int waits [3] = '{1, 3, 0};

    dmem_lsu #(.DEPTH_BYTES(4096), .WAIT_CYCLES(1)) u_d0 (
        .clk(clk), .resetn(resetn[0]),
        .req_valid(req_valid[0]), .req_ready(req_ready[0]),
        .req_we(req_we[0]), .req_size(req_size[0]),
        .req_unsigned(req_unsigned[0]), .req_addr(req_addr[0]),
        .req_wdata(req_wdata[0]), .rsp_valid(rsp_valid[0]),
        .rsp_rdata(rsp_rdata[0]), .rsp_fault(rsp_fault[0])
    );

    dmem_lsu #(.DEPTH_BYTES(4096), .WAIT_CYCLES(3)) u_d1 (
        .clk(clk), .resetn(resetn[1]),
        .req_valid(req_valid[1]), .req_ready(req_ready[1]),
        .req_we(req_we[1]), .req_size(req_size[1]),
        .req_unsigned(req_unsigned[1]), .req_addr(req_addr[1]),
        .req_wdata(req_wdata[1]), .rsp_valid(rsp_valid[1]),
        .rsp_rdata(rsp_rdata[1]), .rsp_fault(rsp_fault[1])
    );

    dmem_lsu #(.DEPTH_BYTES(4096), .WAIT_CYCLES(0)) u_d2 (
        .clk(clk), .resetn(resetn[2]),
        .req_valid(req_valid[2]), .req_ready(req_ready[2]),
        .req_we(req_we[2]), .req_size(req_size[2]),
        .req_unsigned(req_unsigned[2]), .req_addr(req_addr[2]),
        .req_wdata(req_wdata[2]), .rsp_valid(rsp_valid[2]),
        .rsp_rdata(rsp_rdata[2]), .rsp_fault(rsp_fault[2])
    );

    // ---------------- clock ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- checker ----------------
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%08h exp=%08h", tag, got, exp);
        end
    endtask

    // ---------------- driver ----------------
    // Issue one request on instance d and check the full response.
    task automatic access(input int d, input string tag, input logic we,
                          input logic [1:0] size, input logic uns,
                          input logic [31:0] addr, input logic [31:0] wdata,
                          input logic [31:0] exp_rdata, input logic exp_fault);
        int   n;
        logic seen;
        @(negedge clk);
        req_we[d]       = we;
        req_size[d]     = size;
        req_unsigned[d] = uns;
        req_addr[d]     = addr;
        req_wdata[d]    = wdata;
        req_valid[d]    = 1'b1;
        n = 0;
        while (!req_ready[d] && n < 20) begin
            @(negedge clk);
            n++;
        end
        check({tag, "_ready"}, 32'(req_ready[d]), 32'd1);
        @(posedge clk);
        #1 req_valid[d] = 1'b0;
        seen = 1'b0;
        n    = 0;
        while (!seen && n < 20) begin
            @(negedge clk);
            n++;
            if (rsp_valid[d]) seen = 1'b1;
        end
        check({tag, "_lat"},   32'(n), 32'(waits[d] + 1));
        check({tag, "_rdata"}, rsp_rdata[d], exp_rdata);
        check({tag, "_fault"}, 32'(rsp_fault[d]), 32'(exp_fault));
        @(negedge clk);
        check({tag, "_pulse"}, 32'(rsp_valid[d]), 32'd0);
        check({tag, "_hold"},  rsp_rdata[d], exp_rdata);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int accepts;
        int resps;
        int pulses;

        for (int d = 0; d < 3; d++) begin
            resetn[d]       = 1'b0;
            req_valid[d]    = 1'b0;
            req_we[d]       = 1'b0;
            req_size[d]     = 2'b00;
            req_unsigned[d] = 1'b0;
            req_addr[d]     = 32'h0;
            req_wdata[d]    = 32'h0;
        end

        // Reset values while resetn is low.
        repeat (3) @(negedge clk);
        for (int d = 0; d < 3; d++) begin
            check("rst_ready", 32'(req_ready[d]), 32'd0);
            check("rst_valid", 32'(rsp_valid[d]), 32'd0);
            check("rst_rdata", rsp_rdata[d], 32'd0);
            check("rst_fault", 32'(rsp_fault[d]), 32'd0);
        end
        for (int d = 0; d < 3; d++) resetn[d] = 1'b1;
        @(negedge clk);
        check("post_rst_ready", 32'(req_ready[0]), 32'd1);

        // ---- basic word store/load ----
        access(0, "st_w10",  1'b1, 2'b10, 1'b0, 32'h10, 32'hDEADBEEF, 32'h0, 1'b0);
        access(0, "ld_w10",  1'b0, 2'b10, 1'b0, 32'h10, 32'h0, 32'hDEADBEEF, 1'b0);

        // ---- byte store with sign/zero extension ----
        access(0, "st_w20",  1'b1, 2'b10, 1'b0, 32'h20, 32'h11223344, 32'h0, 1'b0);
        access(0, "st_b21",  1'b1, 2'b00, 1'b0, 32'h21, 32'h12345680, 32'h0, 1'b0);
        access(0, "ld_bs21", 1'b0, 2'b00, 1'b0, 32'h21, 32'h0, 32'hFFFFFF80, 1'b0);
        access(0, "ld_bu21", 1'b0, 2'b00, 1'b1, 32'h21, 32'h0, 32'h00000080, 1'b0);
        access(0, "ld_w20",  1'b0, 2'b10, 1'b0, 32'h20, 32'h0, 32'h11228044, 1'b0);
        access(0, "ld_hs22", 1'b0, 2'b01, 1'b0, 32'h22, 32'h0, 32'h00001122, 1'b0);

        // ---- half store and extension ----
        access(0, "st_w30",  1'b1, 2'b10, 1'b0, 32'h30, 32'h00000000, 32'h0, 1'b0);
        access(0, "st_h30",  1'b1, 2'b01, 1'b0, 32'h30, 32'h1234CAFE, 32'h0, 1'b0);
        access(0, "ld_w30",  1'b0, 2'b10, 1'b0, 32'h30, 32'h0, 32'h0000CAFE, 1'b0);
        access(0, "ld_hs30", 1'b0, 2'b01, 1'b0, 32'h30, 32'h0, 32'hFFFFCAFE, 1'b0);
        access(0, "ld_hu30", 1'b0, 2'b01, 1'b1, 32'h30, 32'h0, 32'h0000CAFE, 1'b0);

        // ---- range boundary and illegal size ----
        access(0, "ld_wffe", 1'b0, 2'b10, 1'b0, 32'hFFE, 32'h0, 32'h0, 1'b1);
        access(0, "st_wffc", 1'b1, 2'b10, 1'b0, 32'hFFC, 32'hA5A55A5A, 32'h0, 1'b0);
        access(0, "ld_wffc", 1'b0, 2'b10, 1'b0, 32'hFFC, 32'h0, 32'hA5A55A5A, 1'b0);
        access(0, "ld_bfff", 1'b0, 2'b00, 1'b1, 32'hFFF, 32'h0, 32'h000000A5, 1'b0);
        access(0, "ld_b1000",1'b0, 2'b00, 1'b1, 32'h1000, 32'h0, 32'h0, 1'b1);
        access(0, "st_wffe", 1'b1, 2'b10, 1'b0, 32'hFFE, 32'h01020304, 32'h0, 1'b1);
        access(0, "ld_wffc2",1'b0, 2'b10, 1'b0, 32'hFFC, 32'h0, 32'hA5A55A5A, 1'b0);
        access(0, "ld_wtop", 1'b0, 2'b10, 1'b0, 32'hFFFFFFFF, 32'h0, 32'h0, 1'b1);
        access(0, "ld_sz3",  1'b0, 2'b11, 1'b0, 32'h10, 32'h0, 32'h0, 1'b1);
        access(0, "st_sz3",  1'b1, 2'b11, 1'b0, 32'h10, 32'h0, 32'h0, 1'b1);
        access(0, "ld_w10b", 1'b0, 2'b10, 1'b0, 32'h10, 32'h0, 32'hDEADBEEF, 1'b0);

        // ---- alignment handling ----
        access(0, "st_w00",  1'b1, 2'b10, 1'b0, 32'h0, 32'h11223344, 32'h0, 1'b0);
        access(0, "st_w04",  1'b1, 2'b10, 1'b0, 32'h4, 32'h55667788, 32'h0, 1'b0);
`ifdef DMEM_MISALIGN_TRAP_EN
        access(0, "ld_h03",  1'b0, 2'b01, 1'b0, 32'h3, 32'h0, 32'h0, 1'b1);
        access(0, "st_h03",  1'b1, 2'b01, 1'b0, 32'h3, 32'h0000AAAA, 32'h0, 1'b1);
        access(0, "ld_w00",  1'b0, 2'b10, 1'b0, 32'h0, 32'h0, 32'h11223344, 1'b0);
        access(0, "ld_w05",  1'b0, 2'b10, 1'b0, 32'h5, 32'h0, 32'h0, 1'b1);
`else
        access(0, "ld_h03",  1'b0, 2'b01, 1'b0, 32'h3, 32'h0, 32'h00001122, 1'b0);
        access(0, "st_h03",  1'b1, 2'b01, 1'b0, 32'h3, 32'h0000AAAA, 32'h0, 1'b0);
        access(0, "ld_w00",  1'b0, 2'b10, 1'b0, 32'h0, 32'h0, 32'hAAAA3344, 1'b0);
        access(0, "ld_w05",  1'b0, 2'b10, 1'b0, 32'h5, 32'h0, 32'h55667788, 1'b0);
`endif

        // ---- reset during an in-flight store (WAIT_CYCLES=3) ----
        access(1, "d1_st40", 1'b1, 2'b10, 1'b0, 32'h40, 32'h12345678, 32'h0, 1'b0);
        @(negedge clk);
        req_we[1]    = 1'b1;
        req_size[1]  = 2'b10;
        req_addr[1]  = 32'h40;
        req_wdata[1] = 32'hCAFEBABE;
        req_valid[1] = 1'b1;
        check("d1_acc_ready", 32'(req_ready[1]), 32'd1);
        @(posedge clk);
        #1 req_valid[1] = 1'b0;
        pulses = 0;
        repeat (2) begin
            @(negedge clk);
            if (rsp_valid[1]) pulses++;
        end
        resetn[1] = 1'b0;
        repeat (3) begin
            #1;
            check("d1_rst_ready", 32'(req_ready[1]), 32'd0);
            check("d1_rst_valid", 32'(rsp_valid[1]), 32'd0);
            @(negedge clk);
        end
        resetn[1] = 1'b1;
        repeat (6) begin
            @(negedge clk);
            if (rsp_valid[1]) pulses++;
        end
        check("d1_no_rsp", 32'(pulses), 32'd0);
        access(1, "d1_ld40", 1'b0, 2'b10, 1'b0, 32'h40, 32'h0, 32'hCAFEBABE, 1'b0);

        // ---- back-to-back with req_valid held high (WAIT_CYCLES=0) ----
        @(negedge clk);
        req_we[2]    = 1'b1;
        req_size[2]  = 2'b10;
        req_addr[2]  = 32'h50;
        req_wdata[2] = 32'h13579BDF;
        req_valid[2] = 1'b1;
        accepts = 0;
        resps   = 0;
        for (int i = 0; i < 12; i++) begin
            check("d2_ready_pat", 32'(req_ready[2]), 32'((i % 2) == 0));
            check("d2_rsp_pat",   32'(rsp_valid[2]), 32'((i % 2) == 1));
            if (req_valid[2] && req_ready[2]) accepts++;
            if (rsp_valid[2]) resps++;
            if (i < 11) @(negedge clk);
        end
        req_valid[2] = 1'b0;
        check("d2_accepts", 32'(accepts), 32'd6);
        check("d2_resps",   32'(resps),   32'd6);
        access(2, "d2_ld50", 1'b0, 2'b10, 1'b0, 32'h50, 32'h0, 32'h13579BDF, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    // Global watchdog so the run always ends.
    initial begin
        #200000;
        errors++;
        $display("FAIL watchdog got=timeout exp=finish");
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
